sram_mem_stage: RTL and testbench
=================================

Name: sram_mem_stage

Overview:
- Memory stage of the 5-stage ARM pipeline.
- Consumes the EXE stage outputs (ALU result as address, Rm value as store data, and the control bits).
- Performs 32-bit loads/stores against the off-chip 256K x 16 SRAM as two 16-bit half-accesses.
- Drops ready to freeze the pipeline until the access completes; forwards the write-back controls to the MEM/WB register.

Parameters:
- ACCESS_CYCLES, 3: clock cycles per 16-bit half-access. Legal values are 2 to 15.
- MEM_BASE, 1024: byte address that maps to SRAM word 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_read_in  input  1  load request from EXE.
- mem_write_in  input  1  store request from EXE.
- WB_en_in  input  1  write-back enable from EXE.
- dst_in  input  4  destination register index.
- ALU_res_in  input  32  byte address, or ALU result for non-memory instructions.
- val_Rm_in  input  32  store data.
- ready  output  1  high means the stage can advance; low freezes all upstream pipeline registers.
- WB_en_out  output  1  equals WB_en_in.
- mem_read_out  output  1  equals mem_read_in.
- dst_out  output  4  equals dst_in.
- ALU_res_out  output  32  equals ALU_res_in.
- mem_data_out  output  32  assembled load data (registered).
- sram_addr  output  18  SRAM halfword address.
- sram_dq_out  output  16  SRAM write data.
- sram_dq_oe  output  1  drives sram_dq_out onto the SRAM data bus when high.
- sram_dq_in  input  16  SRAM read data.
- sram_we_n  output  1  SRAM write enable, active-low.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state=IDLE, cycle counter=0.
  - mem_data_out=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
- Address mapping:
  - word = ((ALU_res_in - MEM_BASE) >> 2)[16:0]. Subtraction is modulo 2^32; upper bits are discarded.
  - Low half uses sram_addr={word,0}; high half uses sram_addr={word,1}.
  - Low half carries bits 15:0, high half carries bits 31:16.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- Transitions from IDLE:
  - mem_read_in=1 -> RD_LO.
  - else mem_write_in=1 -> WR_LO.
  - else stay in IDLE.
  - Read wins if both requests are high; that combination is illegal upstream and must not produce a write.
- Half-access phase timing:
  - Each *_LO/*_HI phase lasts exactly ACCESS_CYCLES cycles, counted by the cycle counter.
  - *_LO goes to *_HI, *_HI goes to DONE, DONE goes to IDLE unconditionally.
  - The counter clears on every phase entry.
- Reads:
  - sram_dq_in is sampled on the last cycle of RD_LO into mem_data_out[15:0], and on the last cycle of RD_HI into mem_data_out[31:16].
  - mem_data_out holds its value otherwise.
- Writes:
  - sram_dq_oe=1 for all cycles of WR_LO/WR_HI.
  - sram_dq_out = val_Rm_in[15:0] in WR_LO and val_Rm_in[31:16] in WR_HI.
  - sram_we_n=0 on every cycle of a write phase except its last cycle, which provides address/data hold with we_n high.
- Outside write phases: sram_dq_oe=0 and sram_we_n=1.
- sram_addr is driven combinationally from state and word; it is 0 in IDLE and DONE.
- ready (combinational):
  - 1 when state=IDLE and neither request is high.
  - 1 when state=DONE.
  - 0 otherwise.
- Latency:
  - A memory access holds ready low for 2*ACCESS_CYCLES+1 cycles. That is the IDLE detect cycle plus both phases, with DONE entered one edge later.
  - ready is high in the DONE cycle, so the pipeline advances on the edge that leaves DONE.
  - Non-memory instructions pass with zero stall.
- Upstream inputs are held stable while ready=0. The stage does not latch ALU_res_in or val_Rm_in.
- Back-to-back accesses: after DONE, the next instruction is seen in IDLE on the following cycle. There is no extra bubble beyond IDLE detection.

Test Plan:
- Reset mid-access:
  - Stimulus: assert rst during the 2nd cycle of WR_HI.
  - Response: immediately sram_we_n=1, sram_dq_oe=0, ready=1 (no request after release), mem_data_out=0.
- Store timing:
  - Stimulus: mem_write_in=1, ALU_res_in=1028, val_Rm_in=0xDEADBEEF, ACCESS_CYCLES=3.
  - Response: sram_addr=2 with dq_out=0xBEEF for 3 cycles, then sram_addr=3 with dq_out=0xDEAD for 3 cycles.
  - sram_we_n is low for 2 of 3 cycles in each phase.
  - ready stays low 7 cycles and is high in the DONE cycle.
- Load assembly:
  - Stimulus: mem_read_in=1, ALU_res_in=1024; the SRAM model returns 0x5678 at address 0 and 0x1234 at address 1.
  - Response: mem_data_out=0x12345678 in DONE; sram_we_n stays 1 throughout.
- Non-memory pass-through:
  - Stimulus: WB_en_in=1, dst_in=7, ALU_res_in=42, no request.
  - Response: ready=1 every cycle, outputs equal inputs, no SRAM activity.
- Back-to-back and conflicting requests:
  - Stimulus: a load to 2048 immediately followed by a store to 2052; separately, both mem_read_in and mem_write_in high.
  - Response: the load covers sram_addr 512/513 and the store covers 514/515 with one IDLE cycle between them.
  - With both requests high, a read sequence runs and sram_we_n never goes low.
- Address wrap:
  - Stimulus: ALU_res_in=0 with a load.
  - Response: word=0x1FF00 and sram_addr=0x3FE00 then 0x3FE01.

Source files
------------

// File: rtl/sram_mem_stage.sv
// rtl/sram_mem_stage.sv - ARM pipeline memory stage driving a 256K x 16 SRAM
//
// Performs 32-bit loads/stores as two 16-bit half-accesses of ACCESS_CYCLES
// clocks each, low half first, and freezes the pipeline through ready while
// an access is in flight. Write-back controls pass straight through.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   mem_read_in, mem_write_in      load / store request from EXE
//   WB_en_in, dst_in               write-back controls (passed through)
//   ALU_res_in                     byte address or ALU result
//   val_Rm_in                      store data
//   ready                          high lets upstream stages advance
//   WB_en_out, mem_read_out,
//   dst_out, ALU_res_out           pass-through copies of the inputs
//   mem_data_out                   assembled load data (registered)
//   sram_addr                      SRAM halfword address
//   sram_dq_out, sram_dq_oe        SRAM write data and its output enable
//   sram_dq_in                     SRAM read data
//   sram_we_n                      SRAM write strobe, active-low

module sram_mem_stage #(
   parameter int          ACCESS_CYCLES = 3,
   parameter logic [31:0] MEM_BASE      = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        WB_en_in,
   input  logic [3:0]  dst_in,
   input  logic [31:0] ALU_res_in,
   input  logic [31:0] val_Rm_in,
   output logic        ready,
   output logic        WB_en_out,
   output logic        mem_read_out,
   output logic [3:0]  dst_out,
   output logic [31:0] ALU_res_out,
   output logic [31:0] mem_data_out,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_we_n
);

   typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

   localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;
   logic        last;
   logic        wr_nxt;
   logic [31:0] offset;
   logic [16:0] word;

   assign WB_en_out    = WB_en_in;
   assign mem_read_out = mem_read_in;
   assign dst_out      = dst_in;
   assign ALU_res_out  = ALU_res_in;

   // Subtraction wraps modulo 2^32; only 17 word-address bits reach the SRAM.
   assign offset = ALU_res_in - MEM_BASE;
   assign word   = offset[18:2];
   assign last   = (cnt == LAST);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + 4'd1;
      case (state)
         IDLE: begin
            cnt_nxt = 4'd0;
            if (mem_read_in)       state_nxt = RD_LO;   // read wins on a conflict
            else if (mem_write_in) state_nxt = WR_LO;
         end
         RD_LO: if (last) begin state_nxt = RD_HI; cnt_nxt = 4'd0; end
         RD_HI: if (last) begin state_nxt = DONE;  cnt_nxt = 4'd0; end
         WR_LO: if (last) begin state_nxt = WR_HI; cnt_nxt = 4'd0; end
         WR_HI: if (last) begin state_nxt = DONE;  cnt_nxt = 4'd0; end
         DONE: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   assign wr_nxt = (state_nxt == WR_LO) || (state_nxt == WR_HI);

   // SRAM strobes are registered from the next state so they never glitch;
   // the final cycle of each write phase holds address/data with we_n high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         mem_data_out <= 32'd0;
         sram_dq_out  <= 16'd0;
         sram_dq_oe   <= 1'b0;
         sram_we_n    <= 1'b1;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sram_dq_oe <= wr_nxt;
         sram_we_n  <= !(wr_nxt && (cnt_nxt != LAST));
         case (state_nxt)
            WR_LO:   sram_dq_out <= val_Rm_in[15:0];
            WR_HI:   sram_dq_out <= val_Rm_in[31:16];
            default: sram_dq_out <= 16'd0;
         endcase
         if (state == RD_LO && last) mem_data_out[15:0]  <= sram_dq_in;
         if (state == RD_HI && last) mem_data_out[31:16] <= sram_dq_in;
      end
   end

   always_comb begin
      case (state)
         RD_LO, WR_LO: sram_addr = {word, 1'b0};
         RD_HI, WR_HI: sram_addr = {word, 1'b1};
         default:      sram_addr = 18'd0;
      endcase
   end

   assign ready = ((state == IDLE) && !mem_read_in && !mem_write_in) || (state == DONE);

endmodule

// File: tb/tb_sram_mem_stage.sv
// tb/tb_sram_mem_stage.sv - directed self-checking bench for sram_mem_stage

module tb_sram_mem_stage;

   localparam int AC = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read_in, mem_write_in, WB_en_in;
   logic [3:0]  dst_in;
   logic [31:0] ALU_res_in, val_Rm_in;
   logic        ready, WB_en_out, mem_read_out;
   logic [3:0]  dst_out;
   logic [31:0] ALU_res_out, mem_data_out;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   logic [15:0] model_mem [0:15];

   int checks   = 0;
   int failures = 0;

   sram_mem_stage #(.ACCESS_CYCLES(AC), .MEM_BASE(32'd1024)) dut (
      .clk(clk), .rst(rst),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .WB_en_in(WB_en_in), .dst_in(dst_in),
      .ALU_res_in(ALU_res_in), .val_Rm_in(val_Rm_in),
      .ready(ready), .WB_en_out(WB_en_out), .mem_read_out(mem_read_out),
      .dst_out(dst_out), .ALU_res_out(ALU_res_out), .mem_data_out(mem_data_out),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   always #5 clk = ~clk;

   // Small SRAM model: only the low 4 address bits are decoded.
   always_comb sram_dq_in = model_mem[sram_addr[3:0]];
   always @(posedge clk)
      if (!sram_we_n && sram_dq_oe) model_mem[sram_addr[3:0]] = sram_dq_out;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge. Applies one request and checks every
   // cycle from the IDLE detect cycle through DONE, then drops the request
   // on the edge that leaves DONE.
   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] alu, input logic [31:0] val,
                             input logic [17:0] a_lo, input logic exp_wr,
                             input logic [31:0] exp_data);
      logic        lo, hi, exp_oe, exp_we_n, exp_ready;
      logic [17:0] exp_addr;
      logic [15:0] exp_dq;
      mem_read_in  = rd;
      mem_write_in = wr;
      ALU_res_in   = alu;
      val_Rm_in    = val;
      for (int i = 0; i <= 2*AC+1; i++) begin
         @(negedge clk);
         lo        = (i >= 1) && (i <= AC);
         hi        = (i > AC) && (i <= 2*AC);
         exp_ready = (i == 2*AC+1);
         exp_addr  = lo ? a_lo : (hi ? (a_lo | 18'd1) : 18'd0);
         exp_oe    = exp_wr && (lo || hi);
         exp_we_n  = !(exp_oe && (i != AC) && (i != 2*AC));
         exp_dq    = exp_oe ? (lo ? val[15:0] : val[31:16]) : 16'd0;
         check($sformatf("%s_ready_c%0d", tag, i), 32'(ready), 32'(exp_ready));
         check($sformatf("%s_addr_c%0d", tag, i), 32'(sram_addr), 32'(exp_addr));
         check($sformatf("%s_oe_c%0d", tag, i), 32'(sram_dq_oe), 32'(exp_oe));
         check($sformatf("%s_wen_c%0d", tag, i), 32'(sram_we_n), 32'(exp_we_n));
         check($sformatf("%s_dq_c%0d", tag, i), 32'(sram_dq_out), 32'(exp_dq));
      end
      check($sformatf("%s_data_done", tag), mem_data_out, exp_data);
      @(posedge clk); #1;
      mem_read_in  = 1'b0;
      mem_write_in = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 16; k++) model_mem[k] = 16'h0;
      rst = 1'b1;
      mem_read_in = 1'b0; mem_write_in = 1'b0; WB_en_in = 1'b0;
      dst_in = 4'd0; ALU_res_in = 32'd0; val_Rm_in = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_wen", 32'(sram_we_n), 32'd1);
      check("rst_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_dq", 32'(sram_dq_out), 32'd0);
      check("rst_data", mem_data_out, 32'd0);
      rst = 1'b0;

      // Non-memory pass-through: zero stall, no SRAM activity.
      WB_en_in = 1'b1; dst_in = 4'd7; ALU_res_in = 32'd42;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("pt_ready", 32'(ready), 32'd1);
         check("pt_wb", 32'(WB_en_out), 32'd1);
         check("pt_dst", 32'(dst_out), 32'd7);
         check("pt_alu", ALU_res_out, 32'd42);
         check("pt_mrd", 32'(mem_read_out), 32'd0);
         check("pt_wen", 32'(sram_we_n), 32'd1);
         check("pt_addr", 32'(sram_addr), 32'd0);
      end
      WB_en_in = 1'b0;
      @(posedge clk); #1;

      // Store 0xDEADBEEF to 1028 -> halfwords 2 and 3.
      run_access("st", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2, 1'b1, 32'd0);
      check("st_mem_lo", 32'(model_mem[2]), 32'h0000BEEF);
      check("st_mem_hi", 32'(model_mem[3]), 32'h0000DEAD);

      // Load from 1024: halfwords 0 and 1.
      model_mem[0] = 16'h5678; model_mem[1] = 16'h1234;
      run_access("ld", 1'b1, 1'b0, 32'd1024, 32'h0, 18'd0, 1'b0, 32'h12345678);

      // Back-to-back: load 2048 (512/513) then store 2052 (514/515).
      model_mem[0] = 16'hAAAA; model_mem[1] = 16'hBBBB;
      run_access("b2b_ld", 1'b1, 1'b0, 32'd2048, 32'h0, 18'd512, 1'b0, 32'hBBBBAAAA);
      run_access("b2b_st", 1'b0, 1'b1, 32'd2052, 32'hCAFEF00D, 18'd514, 1'b1, 32'hBBBBAAAA);
      check("b2b_mem_lo", 32'(model_mem[2]), 32'h0000F00D);
      check("b2b_mem_hi", 32'(model_mem[3]), 32'h0000CAFE);

      // Conflicting requests: read sequence, no write strobes.
      model_mem[0] = 16'h1111; model_mem[1] = 16'h2222;
      run_access("both", 1'b1, 1'b1, 32'd1024, 32'h99998888, 18'd0, 1'b0, 32'h22221111);

      // Address wrap: 0 - 1024 -> word 0x1FF00.
      model_mem[0] = 16'h3333; model_mem[1] = 16'h4444;
      run_access("wrap", 1'b1, 1'b0, 32'd0, 32'h0, 18'h3FE00, 1'b0, 32'h44443333);

      // Reset in the 2nd cycle of WR_HI.
      mem_write_in = 1'b1; ALU_res_in = 32'd1028; val_Rm_in = 32'h01234567;
      for (int i = 0; i <= AC+2; i++) @(negedge clk);
      check("mid_wen_pre", 32'(sram_we_n), 32'd0);
      check("mid_addr_pre", 32'(sram_addr), 32'd3);
      rst = 1'b1;
      mem_write_in = 1'b0;
      #1;
      check("mid_wen", 32'(sram_we_n), 32'd1);
      check("mid_oe", 32'(sram_dq_oe), 32'd0);
      check("mid_ready", 32'(ready), 32'd1);
      check("mid_data", mem_data_out, 32'd0);
      check("mid_addr", 32'(sram_addr), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_ready", 32'(ready), 32'd1);
      check("post_wen", 32'(sram_we_n), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
